// File: rtl/bp_nonsynth_commit_driver.sv
// bp_nonsynth_commit_driver: buffers {start pc, run length} descriptors and replays them as one commit packet per active cycle.
// Optional random commit stalls are enabled by defining BP_COMMIT_DRIVER_RAND_STALL_EN.
module bp_nonsynth_commit_driver #(
    parameter int          vaddr_width_p = 39,
    parameter int          dword_width_p = 64,
    parameter int          fifo_els_p    = 4,
    parameter int          gap_width_p   = 4,
    parameter logic [15:0] lfsr_seed_p   = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     reset_li,
    input  logic                     freeze_i,
    input  logic                     entry_v_i,
    input  logic [vaddr_width_p-1:0] entry_pc_i,
    input  logic [7:0]               entry_len_i,
    output logic                     entry_ready_o,
    input  logic [gap_width_p-1:0]   gap_i,
    output logic [vaddr_width_p:0]   commit_pkt_o,
    output logic [dword_width_p-1:0] instret_cnt_o,
    output logic                     idle_o
);
    localparam int ptr_w = $clog2(fifo_els_p);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

    state_e                   state, state_n;
    logic [vaddr_width_p-1:0] fifo_pc [fifo_els_p];
    logic [7:0]               fifo_len [fifo_els_p];
    logic [ptr_w:0]           wr_ptr, rd_ptr;
    logic [vaddr_width_p-1:0] cur_pc, head_pc;
    logic [7:0]               remaining, head_len;
    logic [gap_width_p-1:0]   gap_cnt;
    logic                     empty, full, enq, deq, fire, stall;

`ifdef BP_COMMIT_DRIVER_RAND_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) free-running from the seed; low bits of zero stall a commit
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) lfsr <= lfsr_seed_p;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = lfsr[1:0] == 2'b00;
`else
    logic unused_seed;

    assign unused_seed = ^lfsr_seed_p;
    assign stall       = 1'b0;
`endif

    // Handshake, status and datapath enables derived from current state and FIFO pointers
    always_comb begin
        empty         = wr_ptr == rd_ptr;
        full          = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) && (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);
        entry_ready_o = ~full;
        idle_o        = empty && state == IDLE;
        enq           = entry_v_i && ~full;
        deq           = state == IDLE && ~empty && ~freeze_i;
        fire          = state == ISSUE && ~freeze_i && ~stall;
        head_pc       = fifo_pc[rd_ptr[ptr_w-1:0]];
        head_len      = fifo_len[rd_ptr[ptr_w-1:0]];
    end

    // Descriptor storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_pc[wr_ptr[ptr_w-1:0]]  <= entry_pc_i;
            fifo_len[wr_ptr[ptr_w-1:0]] <= entry_len_i;
        end
    end

    // FIFO pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + (ptr_w+1)'(1);
            if (deq) rd_ptr <= rd_ptr + (ptr_w+1)'(1);
        end
    end

    // Replay FSM state register
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) state <= IDLE;
        else state <= state_n;
    end

    // Next state: zero-length descriptors are popped without leaving IDLE; freeze holds every state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (deq && head_len != 8'd0) ? ISSUE : IDLE;
            ISSUE:   state_n = !fire ? ISSUE : (gap_i != '0) ? GAP : (remaining != 8'd1) ? ISSUE : IDLE;
            GAP:     state_n = (freeze_i || gap_cnt != gap_width_p'(1)) ? GAP : (remaining != 8'd0) ? ISSUE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Run datapath and registered commit packet; pc field holds its last value between commits
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            cur_pc        <= '0;
            remaining     <= '0;
            gap_cnt       <= '0;
            commit_pkt_o  <= '0;
            instret_cnt_o <= '0;
        end else begin
            commit_pkt_o[vaddr_width_p] <= fire;
            if (deq) begin
                cur_pc    <= head_pc;
                remaining <= head_len;
            end
            if (fire) begin
                commit_pkt_o[vaddr_width_p-1:0] <= cur_pc;
                cur_pc        <= cur_pc + vaddr_width_p'(4);
                remaining     <= remaining - 8'd1;
                gap_cnt       <= gap_i;
                instret_cnt_o <= instret_cnt_o + dword_width_p'(1);
            end
            if (state == GAP && !freeze_i) gap_cnt <= gap_cnt - gap_width_p'(1);
        end
    end
endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// tb_bp_nonsynth_commit_driver: scoreboard bench; expected pcs are queued on enqueue and matched by a commit monitor.
module tb_bp_nonsynth_commit_driver;
    localparam int VA = 39;
    localparam int DW = 64;
    localparam int GW = 4;

    logic          clk_i = 1'b0;
    logic          reset_li = 1'b0;
    logic          freeze_i = 1'b0;
    logic          entry_v_i = 1'b0;
    logic [VA-1:0] entry_pc_i = '0;
    logic [7:0]    entry_len_i = '0;
    logic          entry_ready_o;
    logic [GW-1:0] gap_i = '0;
    logic [VA:0]   commit_pkt_o;
    logic [DW-1:0] instret_cnt_o;
    logic          idle_o;

    int              tests = 0;
    int              fails = 0;
    logic [VA-1:0]   exp_q[$];
    longint unsigned exp_cnt = 0;
    logic            frz_edge = 1'b0;
    logic            rnd_on = 1'b0;

    bp_nonsynth_commit_driver dut (
        .clk_i(clk_i), .reset_li(reset_li), .freeze_i(freeze_i), .entry_v_i(entry_v_i),
        .entry_pc_i(entry_pc_i), .entry_len_i(entry_len_i), .entry_ready_o(entry_ready_o),
        .gap_i(gap_i), .commit_pkt_o(commit_pkt_o), .instret_cnt_o(instret_cnt_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // freeze level seen by the edge that may have produced the current packet
    always @(posedge clk_i) frz_edge <= freeze_i;

    // monitor: every instret pulse must match the next expected pc and the running commit count
    always @(negedge clk_i) begin
        if (reset_li && commit_pkt_o[VA]) begin
            exp_cnt++;
            chk("commit_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("commit_pc", 64'(commit_pkt_o[VA-1:0]), 64'(exp_q.pop_front()));
            chk("instret_cnt", instret_cnt_o, exp_cnt);
            chk("commit_while_frozen", 64'(frz_edge), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input string name);
        reset_li  = 1'b0;
        freeze_i  = 1'b0;
        entry_v_i = 1'b0;
        gap_i     = '0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        chk({name, "_pkt"}, 64'(commit_pkt_o), 64'd0);
        chk({name, "_cnt"}, instret_cnt_o, 64'd0);
        chk({name, "_ready"}, 64'(entry_ready_o), 64'd1);
        chk({name, "_idle"}, 64'(idle_o), 64'd1);
        step();
        reset_li = 1'b1;
    endtask

    task automatic push(input logic [VA-1:0] pc, input logic [7:0] len);
        int n = 0;
        logic [VA-1:0] p;
        entry_v_i   = 1'b1;
        entry_pc_i  = pc;
        entry_len_i = len;
        while (!entry_ready_o && n < 2000) begin
            step();
            n++;
        end
        chk("push_ready", 64'(entry_ready_o), 64'd1);
        step();
        entry_v_i = 1'b0;
        p = pc;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(p);
            p = p + VA'(4);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!idle_o && n < 5000) begin
            step();
            n++;
        end
        chk({name, "_idle"}, 64'(idle_o), 64'd1);
        @(negedge clk_i);
        #1;
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (2) step();
        chk("por_pkt", 64'(commit_pkt_o), 64'd0);
        chk("por_cnt", instret_cnt_o, 64'd0);
        chk("por_ready", 64'(entry_ready_o), 64'd1);
        chk("por_idle", 64'(idle_o), 64'd1);
        reset_li = 1'b1;
        step();

        // single run, back-to-back commits, two-edge latency
        push(VA'(39'h0080000000), 8'd3);
        step();
        chk("single_latency", 64'(commit_pkt_o[VA]), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_instret", 64'(commit_pkt_o[VA]), 64'd1);
            chk("single_pc", 64'(commit_pkt_o[VA-1:0]), 64'h80000000 + 64'(4 * i));
        end
        step();
        chk("single_end_instret", 64'(commit_pkt_o[VA]), 64'd0);
        chk("single_end_idle", 64'(idle_o), 64'd1);
        chk("single_end_cnt", instret_cnt_o, 64'd3);

        // gap of 2 gives pulses three cycles apart; changing gap mid-GAP has no effect
        do_reset("gap_rst");
        gap_i = 4'd2;
        push(VA'(39'h100), 8'd2);
        step();
        step();
        chk("gap_first", 64'(commit_pkt_o), {25'd0, 1'b1, 39'h100});
        step();
        chk("gap_bubble1", 64'(commit_pkt_o[VA]), 64'd0);
        gap_i = 4'd5;
        step();
        chk("gap_bubble2", 64'(commit_pkt_o[VA]), 64'd0);
        step();
        chk("gap_second", 64'(commit_pkt_o), {25'd0, 1'b1, 39'h104});
        wait_idle("gap");
        gap_i = '0;

        // fill FIFO while frozen, refused push at full, zero-length descriptor
        do_reset("full_rst");
        freeze_i = 1'b1;
        push(VA'(39'h200), 8'd0);
        push(VA'(39'h300), 8'd1);
        push(VA'(39'h400), 8'd2);
        push(VA'(39'h500), 8'd1);
        chk("full_ready", 64'(entry_ready_o), 64'd0);
        entry_v_i   = 1'b1;
        entry_pc_i  = VA'(39'h900);
        entry_len_i = 8'd1;
        step();
        entry_v_i = 1'b0;
        chk("full_frozen_cnt", instret_cnt_o, 64'd0);
        chk("full_not_idle", 64'(idle_o), 64'd0);
        freeze_i = 1'b0;
        wait_idle("full");
        chk("full_cnt", instret_cnt_o, 64'd4);

        // freeze mid-run pauses at the same pc
        do_reset("frz_rst");
        push(VA'(39'h1000), 8'd5);
        step();
        step();
        chk("frz_c1", 64'(commit_pkt_o), {25'd0, 1'b1, 39'h1000});
        step();
        chk("frz_c2", 64'(commit_pkt_o), {25'd0, 1'b1, 39'h1004});
        freeze_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_hold", 64'(commit_pkt_o[VA]), 64'd0);
        end
        freeze_i = 1'b0;
        step();
        chk("frz_c3", 64'(commit_pkt_o), {25'd0, 1'b1, 39'h1008});
        wait_idle("frz");
        chk("frz_cnt", instret_cnt_o, 64'd5);

        // pc wraps modulo 2^39
        do_reset("wrap_rst");
        push({VA{1'b1}} - VA'(3), 8'd2);
        wait_idle("wrap");
        chk("wrap_cnt", instret_cnt_o, 64'd2);

        // reset mid-run discards the run
        push(VA'(39'h4000), 8'd20);
        repeat (4) step();
        do_reset("midrun_rst");
        repeat (3) step();
        chk("midrun_quiet", 64'(commit_pkt_o[VA]), 64'd0);
        chk("midrun_idle", 64'(idle_o), 64'd1);

        // randomized descriptors, gaps and freezes against the pc-sequence model
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    push(VA'({$urandom, $urandom}), 8'($urandom_range(0, 6)));
                    repeat ($urandom_range(0, 4)) step();
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    step();
                    freeze_i = $urandom_range(0, 3) == 0;
                    gap_i    = GW'($urandom_range(0, 3));
                end
                freeze_i = 1'b0;
                gap_i    = '0;
            end
        join
        wait_idle("rand");
        chk("rand_ready", 64'(entry_ready_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
